key_event_arbiter: RTL and testbench

Collects one-cycle key-press pulses from the 8-key debounce stage and serialises them into a single event stream for the clock's mode/time-setting logic. Presses are buffered per key, served round-robin over a valid/ready handshake, and counted when lost. Optional hold-to-repeat lets a held key generate repeat events for fast time adjustment.

---
 rtl/key_event_arbiter_if.sv | 12 +
 rtl/key_event_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_key_event_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/key_event_arbiter_if.sv
// Event stream between the key arbiter (master) and the mode/time-setting logic (slave).
interface key_event_arbiter_if;
  localparam int unsigned CODE_W = 3;

  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_repeat;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Buffers one-cycle press pulses from 8 keys and serialises them round-robin onto a
// valid/ready event stream, counting lost presses. Hold-to-repeat built under KEY_REPEAT_EN.
module key_event_arbiter #(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic                CLK_50M,
  input  logic                RST_N,
  input  logic [7:0]          key_pulse,
  input  logic [7:0]          key_level,
  key_event_arbiter_if.master evt,
  output logic [7:0]          drop_cnt
);
  localparam int unsigned N_KEYS = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned LOST_W = 4;
  localparam int unsigned TMR_W  = 25;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_KEYS-1:0] r_pend;
  logic [CODE_W-1:0] r_last_code;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_load;
  logic              w_load_press;
  logic              w_load_rpt;
  logic              w_win_found;
  logic [CODE_W-1:0] w_win_code;
  logic [CODE_W-1:0] w_cand;
  logic [N_KEYS-1:0] w_clr;
  logic [N_KEYS-1:0] w_lost;
  logic [N_KEYS-1:0] w_pend_nxt;
  logic [LOST_W-1:0] w_lost_num;
  logic [SUM_W-1:0]  w_drop_sum;
  logic [CNT_W-1:0]  w_drop_nxt;
  logic              w_rpt_avail;
  logic [CODE_W-1:0] w_rpt_code;

  assign w_load = !r_valid || evt.evt_ready;

  // Round-robin search starting just after the last loaded press.
  always_comb begin
    w_win_found = 1'b0;
    w_win_code  = '0;
    w_cand      = '0;
    for (int unsigned i = 1; i <= N_KEYS; i++) begin
      w_cand = r_last_code + CODE_W'(i);
      if (!w_win_found && r_pend[w_cand]) begin
        w_win_found = 1'b1;
        w_win_code  = w_cand;
      end
    end
  end

  assign w_load_press = w_load && w_win_found;
  assign w_load_rpt   = w_load && !w_win_found && w_rpt_avail;
  assign w_clr        = w_load_press ? (N_KEYS'(1) << w_win_code) : '0;
  assign w_pend_nxt   = (r_pend & ~w_clr) | key_pulse;
  assign w_lost       = key_pulse & r_pend & ~w_clr;

  always_comb begin
    w_lost_num = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      w_lost_num = w_lost_num + LOST_W'(w_lost[i]);
    end
  end

  assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_lost_num);
  assign w_drop_nxt = (w_drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_drop_sum[CNT_W-1:0];

  // Pending set, drop counter and output register; code is kept when the register empties.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_pend      <= '0;
      r_last_code <= '1;
      r_valid     <= 1'b0;
      r_code      <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (w_load_press) begin
        r_valid     <= 1'b1;
        r_code      <= w_win_code;
        r_last_code <= w_win_code;
      end else if (w_load_rpt) begin
        r_valid <= 1'b1;
        r_code  <= w_rpt_code;
      end else if (w_load) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = r_valid;
  assign evt.evt_code  = r_code;
  assign drop_cnt      = r_drop_cnt;

`ifdef KEY_REPEAT_EN
  typedef enum logic {RPT_IDLE, RPT_ARMED} rpt_state_e;

  rpt_state_e        r_rpt_state;
  rpt_state_e        w_rpt_state_nxt;
  logic [CODE_W-1:0] r_rpt_key;
  logic [CODE_W-1:0] w_rpt_key_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic              r_rpt_pend;
  logic              w_rpt_pend_nxt;
  logic              r_repeat;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_rpt_state <= RPT_IDLE;
      r_rpt_key   <= '0;
      r_timer     <= '0;
      r_rpt_pend  <= 1'b0;
    end else begin
      r_rpt_state <= w_rpt_state_nxt;
      r_rpt_key   <= w_rpt_key_nxt;
      r_timer     <= w_timer_nxt;
      r_rpt_pend  <= w_rpt_pend_nxt;
    end
  end

  // A loaded press always re-arms; otherwise release disarms, else the timer runs.
  always_comb begin
    w_rpt_state_nxt = r_rpt_state;
    w_rpt_key_nxt   = r_rpt_key;
    w_timer_nxt     = r_timer;
    w_rpt_pend_nxt  = r_rpt_pend;
    if (w_load_press) begin
      w_rpt_state_nxt = RPT_ARMED;
      w_rpt_key_nxt   = w_win_code;
      w_timer_nxt     = TMR_W'(REPEAT_DELAY);
      w_rpt_pend_nxt  = 1'b0;
    end else begin
      case (r_rpt_state)
        RPT_IDLE: begin
          w_rpt_pend_nxt = 1'b0;
        end
        RPT_ARMED: begin
          if (key_level[r_rpt_key]) begin
            w_rpt_state_nxt = RPT_IDLE;
            w_timer_nxt     = '0;
            w_rpt_pend_nxt  = 1'b0;
          end else begin
            if (w_load_rpt) begin
              w_rpt_pend_nxt = 1'b0;
            end
            if (r_timer <= TMR_W'(1)) begin
              w_rpt_pend_nxt = 1'b1;
              w_timer_nxt    = TMR_W'(REPEAT_RATE);
            end else begin
              w_timer_nxt = r_timer - TMR_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_repeat <= 1'b0;
    end else if (w_load) begin
      r_repeat <= w_load_rpt;
    end
  end

  assign w_rpt_avail    = r_rpt_pend;
  assign w_rpt_code     = r_rpt_key;
  assign evt.evt_repeat = r_repeat;
`else
  logic w_unused_cfg;

  assign w_rpt_avail    = 1'b0;
  assign w_rpt_code     = '0;
  assign evt.evt_repeat = 1'b0;
  assign w_unused_cfg   = ^{key_level, TMR_W'(REPEAT_DELAY), TMR_W'(REPEAT_RATE)};
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed vector table, drop saturation, randomized run
// against a behavioural model, reset-while-busy, and hold-to-repeat when KEY_REPEAT_EN is set.
module tb_key_event_arbiter;
  localparam int unsigned DLY  = 10;
  localparam int unsigned RATE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_pulse = 8'h00;
  logic [7:0] key_level = 8'hFF;
  logic [7:0] drop_cnt;

  key_event_arbiter_if evt_if ();

  key_event_arbiter #(
    .REPEAT_DELAY (DLY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .CLK_50M   (clk),
    .RST_N     (rst_n),
    .key_pulse (key_pulse),
    .key_level (key_level),
    .evt       (evt_if.master),
    .drop_cnt  (drop_cnt)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic [7:0] pulse;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[17];

  // Behavioural model state
  logic [7:0] m_pend;
  int         m_last;
  logic       m_valid;
  int         m_code;
  int         m_drop;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] pulse, input logic ready,
                      input logic [7:0] level);
    @(negedge clk);
    rst_n            = !rst;
    key_pulse        = pulse;
    evt_if.evt_ready = ready;
    key_level        = level;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend  = 8'h00;
    m_last  = 7;
    m_valid = 1'b0;
    m_code  = 0;
    m_drop  = 0;
  endtask

  task automatic model_step(input logic [7:0] pulse, input logic ready);
    int   win;
    int   lost;
    int   c;
    logic load;
    win  = -1;
    lost = 0;
    load = !m_valid || ready;
    if (load) begin
      for (int k = 1; k <= 8; k++) begin
        c = (m_last + k) % 8;
        if (win < 0 && m_pend[c]) win = c;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (pulse[i] && m_pend[i] && i != win) lost++;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == win) m_pend[i] = pulse[i];
      else if (pulse[i]) m_pend[i] = 1'b1;
    end
    if (load) begin
      if (win >= 0) begin
        m_valid = 1'b1;
        m_code  = win;
        m_last  = win;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
  endtask

  initial begin
    logic [7:0] pulse;
    logic       ready;
    int         exp_drop;
    logic       exp_v;

    evt_if.evt_ready = 1'b0;

    // rst, pulse, ready -> valid, code, drop
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[1]  = '{1'b0, 8'h20, 1'b1, 1'b0, 3'd0, 8'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[5]  = '{1'b0, 8'h45, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 8'd0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd6, 8'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0};
    vecs[11] = '{1'b0, 8'h08, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[12] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'd0};
    vecs[13] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'd1};
    vecs[14] = '{1'b0, 8'h08, 1'b1, 1'b1, 3'd3, 8'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 8'd1};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd1};

    for (int v = 0; v < 17; v++) begin
      step(vecs[v].rst, vecs[v].pulse, vecs[v].ready, 8'hFF);
      check($sformatf("vec%0d valid", v), int'(evt_if.evt_valid), int'(vecs[v].exp_valid));
      if (vecs[v].exp_valid || vecs[v].rst)
        check($sformatf("vec%0d code", v), int'(evt_if.evt_code), int'(vecs[v].exp_code));
      check($sformatf("vec%0d repeat", v), int'(evt_if.evt_repeat), 0);
      check($sformatf("vec%0d drop", v), int'(drop_cnt), int'(vecs[v].exp_drop));
    end

    // Drop counter saturation: key 4 hammered with the consumer stalled
    for (int k = 1; k <= 305; k++) begin
      step(1'b0, 8'h10, 1'b0, 8'hFF);
      exp_drop = 1 + ((k >= 3) ? k - 2 : 0);
      if (exp_drop > 255) exp_drop = 255;
      check("sat drop", int'(drop_cnt), exp_drop);
      if (k == 2) check("sat code", int'(evt_if.evt_code), 4);
    end
    step(1'b0, 8'h00, 1'b1, 8'hFF);
    check("sat drain valid", int'(evt_if.evt_valid), 1);
    check("sat drain code", int'(evt_if.evt_code), 4);
    step(1'b0, 8'h00, 1'b1, 8'hFF);
    check("sat drain empty", int'(evt_if.evt_valid), 0);
    check("sat drop hold", int'(drop_cnt), 255);

    // Randomized run against the model
    step(1'b1, 8'h00, 1'b0, 8'hFF);
    model_reset();
    check("rand reset drop", int'(drop_cnt), 0);
    for (int n = 0; n < 1500; n++) begin
      pulse = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      step(1'b0, pulse, ready, 8'hFF);
      model_step(pulse, ready);
      check("rand valid", int'(evt_if.evt_valid), int'(m_valid));
      if (m_valid) check("rand code", int'(evt_if.evt_code), m_code);
      check("rand repeat", int'(evt_if.evt_repeat), 0);
      check("rand drop", int'(drop_cnt), m_drop);
    end

`ifdef KEY_REPEAT_EN
    // Hold key 1: press at load edge L=step 1, repeats at L+DLY+1 then every RATE; release at 27
    step(1'b1, 8'h00, 1'b1, 8'hFF);
    step(1'b0, 8'h02, 1'b1, 8'hFD);
    for (int t = 1; t <= 45; t++) begin
      step(1'b0, 8'h00, 1'b1, (t >= 27) ? 8'hFF : 8'hFD);
      exp_v = (t == 1) ||
              (t >= int'(DLY) + 2 && t <= 26 && ((t - int'(DLY) - 2) % int'(RATE)) == 0);
      check($sformatf("rpt valid t%0d", t), int'(evt_if.evt_valid), int'(exp_v));
      if (exp_v) begin
        check("rpt code", int'(evt_if.evt_code), 1);
        check("rpt flag", int'(evt_if.evt_repeat), (t > 1) ? 1 : 0);
      end
    end
`endif

    // Reset while presses pend and the tracker is armed
    step(1'b1, 8'h00, 1'b0, 8'hFF);
    step(1'b0, 8'h02, 1'b0, 8'hFD);
    step(1'b0, 8'h28, 1'b0, 8'hFD);
    check("busy code", int'(evt_if.evt_code), 1);
    step(1'b0, 8'h08, 1'b0, 8'hFD);
    check("busy drop", int'(drop_cnt), 1);
    step(1'b1, 8'h00, 1'b0, 8'hFD);
    check("mid rst valid", int'(evt_if.evt_valid), 0);
    check("mid rst code", int'(evt_if.evt_code), 0);
    check("mid rst repeat", int'(evt_if.evt_repeat), 0);
    check("mid rst drop", int'(drop_cnt), 0);
    for (int n = 0; n < 30; n++) begin
      step(1'b0, 8'h00, 1'(n % 2), 8'hFD);
      check("post rst idle", int'(evt_if.evt_valid), 0);
    end
    step(1'b0, 8'h40, 1'b1, 8'hFD);
    check("post rst latency", int'(evt_if.evt_valid), 0);
    step(1'b0, 8'h00, 1'b1, 8'hFD);
    check("post rst valid", int'(evt_if.evt_valid), 1);
    check("post rst code", int'(evt_if.evt_code), 6);
    check("post rst repeat", int'(evt_if.evt_repeat), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
